// File: rtl/uart_param_framer_if.sv
// uart_param_framer_if: byte stream, response handshake and committed-parameter bus of the framer
interface uart_param_framer_if #(
    parameter int PARAM_BYTES = 26,
    parameter int CHANNELS    = 4
);
    localparam int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    logic [7:0]                      rx_data;
    logic                            rx_valid;
    logic [7:0]                      tx_data;
    logic                            tx_send;
    logic                            tx_ready;
    logic [CHANNELS*PARAM_BYTES*8-1:0] params;
    logic                            params_ready;
    logic [CH_W-1:0]                 params_channel;
    logic [7:0]                      error_count;
    modport master (
        output rx_data, rx_valid, tx_ready,
        input  tx_data, tx_send, params, params_ready, params_channel, error_count
    );
    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output tx_data, tx_send, params, params_ready, params_channel, error_count
    );
endinterface

// File: rtl/uart_param_framer.sv
// uart_param_framer: parses SYNC/id/payload/XOR frames into per-channel parameter sets, answers ACK/NAK
module uart_param_framer #(
    parameter int         PARAM_BYTES    = 26,
    parameter int         CHANNELS       = 4,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter logic [7:0] ACK_BYTE       = 8'h06,
    parameter logic [7:0] NAK_BYTE       = 8'h15,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input logic                  clk,
    input logic                  rstn,
    uart_param_framer_if.slave   bus
);
    localparam int CH_W  = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    localparam int PW    = PARAM_BYTES * 8;
    localparam int IDX_W = PARAM_BYTES > 1 ? $clog2(PARAM_BYTES) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, CHAN, PAYLOAD, CHECK} state_t;

    state_t                 r_state;
    logic [7:0]             r_xor;
    logic [7:0]             r_id;
    logic [IDX_W-1:0]       r_idx;
    logic [PW-1:0]          r_shadow;
    logic [CHANNELS*PW-1:0] r_params;
    logic                   r_params_ready;
    logic [CH_W-1:0]        r_params_channel;
    logic [7:0]             r_tx_data;
    logic                   r_tx_send;
    logic                   r_pending;
    logic [7:0]             r_err;
    logic [TO_W-1:0]        r_tcnt;

    logic       w_timeout;
    logic       w_valid_frame;
    logic       w_queue;
    logic [7:0] w_resp;

    // a byte arriving on the cycle the timeout would expire counts as activity
    assign w_timeout     = r_state != IDLE && !bus.rx_valid && r_tcnt == TO_W'(TIMEOUT_CYCLES - 1);
    assign w_valid_frame = bus.rx_data == r_xor && 32'(r_id) < CHANNELS;
    assign w_queue       = r_state == CHECK && bus.rx_valid;
    assign w_resp        = w_valid_frame ? ACK_BYTE : NAK_BYTE;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state          <= IDLE;
            r_xor            <= '0;
            r_id             <= '0;
            r_idx            <= '0;
            r_shadow         <= '0;
            r_params         <= '0;
            r_params_ready   <= 1'b0;
            r_params_channel <= '0;
            r_tx_data        <= '0;
            r_tx_send        <= 1'b0;
            r_pending        <= 1'b0;
            r_err            <= '0;
            r_tcnt           <= '0;
        end else begin
            r_params_ready <= 1'b0;
            r_tcnt         <= (bus.rx_valid || r_state == IDLE || w_timeout) ? '0 : r_tcnt + TO_W'(1);
            if (w_timeout) begin
                r_state  <= IDLE;
                r_shadow <= '0;
                r_err    <= (r_err == 8'hFF) ? r_err : r_err + 8'd1;
            end else if (bus.rx_valid) begin
                case (r_state)
                    IDLE: if (bus.rx_data == SYNC_BYTE) begin
                        r_state <= CHAN;
                        r_xor   <= '0;
                        r_idx   <= IDX_W'(PARAM_BYTES - 1);
                    end
                    CHAN: begin
                        r_id    <= bus.rx_data;
                        r_xor   <= bus.rx_data;
                        r_state <= PAYLOAD;
                    end
                    PAYLOAD: begin
                        r_shadow[8*r_idx +: 8] <= bus.rx_data;
                        r_xor                  <= r_xor ^ bus.rx_data;
                        if (r_idx == '0) r_state <= CHECK;
                        else r_idx <= r_idx - IDX_W'(1);
                    end
                    default: begin
                        r_state <= IDLE;
                        if (w_valid_frame) begin
                            r_params[PW*r_id[CH_W-1:0] +: PW] <= r_shadow;
                            r_params_ready                     <= 1'b1;
                            r_params_channel                   <= r_id[CH_W-1:0];
                        end else begin
                            r_err <= (r_err == 8'hFF) ? r_err : r_err + 8'd1;
                        end
                    end
                endcase
            end
            // single-entry response slot: a newer response replaces an unsent one
            if (w_queue) begin
                r_tx_data <= w_resp;
                r_tx_send <= bus.tx_ready;
                r_pending <= !bus.tx_ready;
            end else if (r_pending && bus.tx_ready) begin
                r_tx_send <= 1'b1;
                r_pending <= 1'b0;
            end else begin
                r_tx_send <= 1'b0;
            end
        end
    end

    assign bus.tx_data        = r_tx_data;
    assign bus.tx_send        = r_tx_send;
    assign bus.params         = r_params;
    assign bus.params_ready   = r_params_ready;
    assign bus.params_channel = r_params_channel;
    assign bus.error_count    = r_err;
endmodule
